axi_wr_burst_split: RTL and testbench
=====================================

AXI_WR_BURST_SPLIT -- requirements
Module: axi_wr_burst_split

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: data width; matches the 32-bit master side of the upstream width adapter.
REQ-003 The block SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: strobe width.
REQ-004 The block SHALL have parameter ID_WIDTH, default 8: ID width.
REQ-005 The block SHALL have parameter MAX_BURST_LEN, default 16: maximum beats per downstream burst; power of 2, range 1..256.
REQ-006 The block SHALL have clk (input, 1 bit): the single clock; all logic is rising-edge.
REQ-007 The block SHALL have rst_n (input, 1 bit): asynchronous, active-low reset.
REQ-008 The block SHALL have s_axi_aw* inputs awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awlock, awcache[3:0], awprot[2:0], awqos[3:0], awregion[3:0] and awvalid, plus awready as an output: the upstream write-address slave channel.
REQ-009 The block SHALL have s_axi_wdata, s_axi_wstrb, s_axi_wlast and s_axi_wvalid as inputs, and s_axi_wready as an output: the upstream write-data slave channel.
REQ-010 The block SHALL have s_axi_bid[ID_WIDTH], s_axi_bresp[2] and s_axi_bvalid as outputs, and s_axi_bready as an input: the upstream write-response slave channel.
REQ-011 The block SHALL have m_axi_aw*, m_axi_w* and m_axi_b* ports mirroring the slave channels with opposite directions: the downstream master channels.

Function
REQ-012 State machine: IDLE, ADDR, DATA, RESP_WAIT, RESP_OUT.
REQ-013 s_axi_awready SHALL be 1 only in IDLE; an AW handshake SHALL latch all AW fields, set the remaining-beat count to awlen+1, and move to ADDR.
REQ-014 In ADDR, m_axi_awvalid SHALL be 1.
REQ-015 In ADDR, m_axi_awaddr SHALL be the current address and m_axi_awlen SHALL be min(remaining, MAX_BURST_LEN)-1.
REQ-016 In ADDR, the remaining m_axi_aw* fields SHALL be copied from the latched values.
REQ-017 On the m_axi_aw handshake, the block SHALL increment the outstanding-B counter and move to DATA.
REQ-018 Only INCR bursts (awburst=2'b01) SHALL be split; FIXED and WRAP bursts SHALL be forwarded as one unmodified burst, and bursts of MAX_BURST_LEN beats or fewer are likewise unsplit.
REQ-019 Address step per INCR sub-burst SHALL be beats<<awsize, computed at ADDR_WIDTH bits; wrap modulo 2^ADDR_WIDTH.
REQ-020 In DATA, W SHALL pass combinationally: m_axi_wvalid=s_axi_wvalid, s_axi_wready=m_axi_wready, with wdata and wstrb copied through.
REQ-021 In DATA, m_axi_wlast SHALL be 1 on the final beat of the current sub-burst; the incoming s_axi_wlast SHALL be ignored.
REQ-022 In all states other than DATA, s_axi_wready and m_axi_wvalid SHALL be 0.
REQ-023 After the last beat of a sub-burst, the block SHALL go to ADDR if beats remain, otherwise to RESP_WAIT.
REQ-024 m_axi_bready SHALL be 1 in every state except IDLE and RESP_OUT; each B handshake SHALL decrement the outstanding count and fold bresp into the merged response.
REQ-025 If a B handshake and an AW handshake occur in the same cycle, the outstanding count SHALL be unchanged.
REQ-026 RESP_WAIT SHALL exit to RESP_OUT in the cycle after the outstanding count reaches 0.
REQ-027 In RESP_OUT, s_axi_bvalid SHALL be 1, with bid equal to the latched awid and bresp equal to the merged response.
REQ-028 A handshake in RESP_OUT SHALL move the block to IDLE and clear the merged response to OKAY.
REQ-029 Only one upstream burst SHALL be in flight at a time.
REQ-030 m_axi_bid SHALL be ignored.

Reset
REQ-031 While rst_n=0, the block SHALL hold state IDLE, counters 0 and merged response 2'b00.
REQ-032 While rst_n=0, all valid and ready outputs SHALL be 0, including s_axi_awready.
REQ-033 After rst_n deasserts, s_axi_awready SHALL rise on the first clk edge.
REQ-034 A reset mid-burst SHALL abandon the transaction with no residual output activity.

Configuration
REQ-035 With macro AXI_WR_SPLIT_WORST_RESP_EN defined, the merged response SHALL be the numerically highest bresp among all sub-bursts (DECERR > SLVERR > EXOKAY > OKAY).
REQ-036 Without AXI_WR_SPLIT_WORST_RESP_EN, the merged response SHALL be the bresp of the final B received.

Verification
REQ-037 INCR awaddr=0x1000, awlen=39, awsize=2, MAX=16 -> three downstream bursts: 0x1000/len15, 0x1040/len15, 0x1080/len7; m_wlast on beats 16, 32 and 40; exactly one s_axi_bvalid.
REQ-038 INCR awlen=3 -> one burst with awlen=3 and address unchanged.
REQ-039 WRAP awlen=31 -> one unsplit burst with awlen=31 and burst=2'b10.
REQ-040 INCR awlen=31, B responses OKAY then SLVERR -> s_axi_bresp=2'b10 under both settings; B responses SLVERR then OKAY -> 2'b10 with the macro, 2'b00 without.
REQ-041 Randomized m_axi_wready/awready/bvalid stalls and s_axi_bready held low for 5 cycles -> no data loss; bid matches awid.
REQ-042 rst_n pulsed low during DATA beat 7 -> all valid outputs 0 immediately; the next burst completes normally.

Source files
------------

// File: rtl/axi_wr_burst_split_if.sv
// AXI4 write-channel bundle (AW/W/B) shared by both sides of axi_wr_burst_split.
interface axi_wr_burst_split_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
);
   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic [3:0]            awqos;
   logic [3:0]            awregion;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;
   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bid, bresp, bvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_wr_burst_split.sv
// Splits long upstream INCR write bursts into MAX_BURST_LEN-beat sub-bursts, merging the B responses.
// Define AXI_WR_SPLIT_WORST_RESP_EN to report the worst sub-burst bresp instead of the last one.
module axi_wr_burst_split #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int STRB_WIDTH    = DATA_WIDTH / 8,
   parameter int ID_WIDTH      = 8,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axi_wr_burst_split_if.slave    s_axi,
   axi_wr_burst_split_if.master   m_axi
);

   if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > 256 || (MAX_BURST_LEN & (MAX_BURST_LEN - 1)) != 0 ||
       STRB_WIDTH * 8 != DATA_WIDTH) begin : g_bad_cfg
      $error("axi_wr_burst_split: invalid MAX_BURST_LEN or STRB_WIDTH");
   end

   localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST_LEN);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP_WAIT, RESP_OUT} state_t;

   state_t                state_q, state_d;
   logic                  rst_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic                  lock_q;
   logic [3:0]            cache_q, qos_q, region_q;
   logic [2:0]            prot_q;
   logic [8:0]            rem_q;
   logic [7:0]            beat_q;
   logic [8:0]            outst_q;
   logic [1:0]            resp_q, resp_merged;
   logic [8:0]            sub_beats;
   logic                  awready_s, awvalid_m, wready_s, wvalid_m, wlast_m, bready_m, bvalid_s;
   logic                  aw_hs_s, aw_hs_m, w_hs, b_hs_m, b_hs_s;
   logic                  unused_ok;

   assign unused_ok = ^{s_axi.wlast, m_axi.bid};

   // Non-INCR bursts always go out whole; rem_q never exceeds 256 beats.
   assign sub_beats = (burst_q == 2'b01 && rem_q > MAX_BEATS) ? MAX_BEATS : rem_q;

   assign aw_hs_s = s_axi.awvalid & awready_s;
   assign aw_hs_m = awvalid_m & m_axi.awready;
   assign w_hs    = wvalid_m & m_axi.wready;
   assign b_hs_m  = m_axi.bvalid & bready_m;
   assign b_hs_s  = bvalid_s & s_axi.bready;

`ifdef AXI_WR_SPLIT_WORST_RESP_EN
   assign resp_merged = (m_axi.bresp > resp_q) ? m_axi.bresp : resp_q;
`else
   assign resp_merged = m_axi.bresp;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      awready_s = 1'b0;
      awvalid_m = 1'b0;
      wready_s  = 1'b0;
      wvalid_m  = 1'b0;
      wlast_m   = 1'b0;
      bready_m  = 1'b0;
      bvalid_s  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // rst_q keeps awready low until the first edge after reset release
            awready_s = rst_q;
            if (s_axi.awvalid && rst_q) state_d = ADDR;
         end
         ADDR: begin
            awvalid_m = 1'b1;
            bready_m  = 1'b1;
            if (m_axi.awready) state_d = DATA;
         end
         DATA: begin
            wvalid_m = s_axi.wvalid;
            wready_s = m_axi.wready;
            wlast_m  = (beat_q == 8'd0);
            bready_m = 1'b1;
            if (s_axi.wvalid && m_axi.wready && beat_q == 8'd0)
               state_d = (rem_q != 9'd0) ? ADDR : RESP_WAIT;
         end
         RESP_WAIT: begin
            bready_m = 1'b1;
            if (outst_q == 9'd0) state_d = RESP_OUT;
         end
         RESP_OUT: begin
            bvalid_s = 1'b1;
            if (s_axi.bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_q    <= 1'b0;
         id_q     <= '0;
         addr_q   <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         lock_q   <= 1'b0;
         cache_q  <= '0;
         prot_q   <= '0;
         qos_q    <= '0;
         region_q <= '0;
         rem_q    <= '0;
         beat_q   <= '0;
         outst_q  <= '0;
         resp_q   <= 2'b00;
      end else begin
         rst_q <= 1'b1;
         if (aw_hs_s) begin
            id_q     <= s_axi.awid;
            addr_q   <= s_axi.awaddr;
            size_q   <= s_axi.awsize;
            burst_q  <= s_axi.awburst;
            lock_q   <= s_axi.awlock;
            cache_q  <= s_axi.awcache;
            prot_q   <= s_axi.awprot;
            qos_q    <= s_axi.awqos;
            region_q <= s_axi.awregion;
            rem_q    <= 9'(s_axi.awlen) + 9'd1;
         end
         if (aw_hs_m) begin
            rem_q  <= rem_q - sub_beats;
            addr_q <= addr_q + (ADDR_WIDTH'(sub_beats) << size_q);
            beat_q <= 8'(sub_beats - 9'd1);
         end
         if (w_hs && beat_q != 8'd0) beat_q <= beat_q - 8'd1;
         case ({aw_hs_m, b_hs_m})
            2'b10:   outst_q <= outst_q + 9'd1;
            2'b01:   outst_q <= outst_q - 9'd1;
            default: outst_q <= outst_q;
         endcase
         if (b_hs_m) resp_q <= resp_merged;
         if (b_hs_s) resp_q <= 2'b00;
      end
   end

   assign s_axi.awready  = awready_s;
   assign s_axi.wready   = wready_s;
   assign s_axi.bvalid   = bvalid_s;
   assign s_axi.bid      = id_q;
   assign s_axi.bresp    = resp_q;

   assign m_axi.awid     = id_q;
   assign m_axi.awaddr   = addr_q;
   assign m_axi.awlen    = 8'(sub_beats - 9'd1);
   assign m_axi.awsize   = size_q;
   assign m_axi.awburst  = burst_q;
   assign m_axi.awlock   = lock_q;
   assign m_axi.awcache  = cache_q;
   assign m_axi.awprot   = prot_q;
   assign m_axi.awqos    = qos_q;
   assign m_axi.awregion = region_q;
   assign m_axi.awvalid  = awvalid_m;
   assign m_axi.wdata    = s_axi.wdata;
   assign m_axi.wstrb    = s_axi.wstrb;
   assign m_axi.wlast    = wlast_m;
   assign m_axi.wvalid   = wvalid_m;
   assign m_axi.bready   = bready_m;

endmodule

// File: tb/tb_axi_wr_burst_split.sv
// Directed bench for axi_wr_burst_split: split geometry, W pass-through, B merging, stalls, reset.
module tb_axi_wr_burst_split;
   localparam int AW = 32, DW = 32, SW = 4, IW = 8, MAXB = 16, TMO = 400;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   axi_wr_burst_split_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) s_if ();
   axi_wr_burst_split_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) m_if ();

   axi_wr_burst_split #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
                        .MAX_BURST_LEN(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .s_axi(s_if.slave), .m_axi(m_if.master));

   int checks = 0, failures = 0;
   int stall = 0;
   int pending = 0, b_idx = 0;
   logic [1:0] plan [8];
   int aw_n = 0, w_n = 0, wl_n = 0, sb_n = 0;
   logic [AW-1:0] aw_addr_log [8];
   logic [7:0]    aw_len_log  [8];
   logic [1:0]    aw_burst_log[8];
   logic [DW-1:0] w_data_log  [64];
   logic [SW-1:0] w_strb_log  [64];
   int            wlast_log   [8];
   logic [IW-1:0] sb_id;
   logic [1:0]    sb_resp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input int tag, input int i);
      return {8'hA5, 8'(tag), 16'(i)};
   endfunction

   function automatic logic [SW-1:0] exp_strb(input int i);
      return SW'(i + 1);
   endfunction

   // downstream slave: drives ready/B on negedge
   always @(negedge clk) begin
      if (!rst_n) begin
         m_if.awready = 1'b0;
         m_if.wready  = 1'b0;
         m_if.bvalid  = 1'b0;
         m_if.bresp   = 2'b00;
      end else begin
         m_if.awready = (stall == 0) || ($urandom_range(0, 2) != 0);
         m_if.wready  = (stall == 0) || ($urandom_range(0, 2) != 0);
         if (pending > 0) begin
            if (m_if.bvalid || stall == 0 || $urandom_range(0, 1) == 1) begin
               m_if.bvalid = 1'b1;
               m_if.bresp  = plan[b_idx & 7];
            end
         end else begin
            m_if.bvalid = 1'b0;
         end
      end
   end

   // handshake monitor
   always @(posedge clk) begin
      if (rst_n) begin
         if (m_if.awvalid && m_if.awready && aw_n < 8) begin
            aw_addr_log[aw_n]  = m_if.awaddr;
            aw_len_log[aw_n]   = m_if.awlen;
            aw_burst_log[aw_n] = m_if.awburst;
            aw_n++;
         end
         if (m_if.wvalid && m_if.wready && w_n < 64) begin
            w_data_log[w_n] = m_if.wdata;
            w_strb_log[w_n] = m_if.wstrb;
            if (m_if.wlast) begin
               if (wl_n < 8) wlast_log[wl_n] = w_n + 1;
               wl_n++;
               pending++;
            end
            w_n++;
         end
         if (m_if.bvalid && m_if.bready) begin
            pending--;
            b_idx++;
         end
         if (s_if.bvalid && s_if.bready) begin
            sb_n++;
            sb_id   = s_if.bid;
            sb_resp = s_if.bresp;
         end
      end
   end

   task automatic clear_logs();
      aw_n = 0; w_n = 0; wl_n = 0; sb_n = 0; pending = 0; b_idx = 0;
      for (int i = 0; i < 8; i++) plan[i] = 2'b00;
   endtask

   task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int t;
      @(negedge clk);
      s_if.awid = id; s_if.awaddr = addr; s_if.awlen = len; s_if.awsize = size; s_if.awburst = burst;
      s_if.awlock = 1'b0; s_if.awcache = 4'h3; s_if.awprot = 3'h0; s_if.awqos = 4'h0; s_if.awregion = 4'h0;
      s_if.awvalid = 1'b1;
      for (t = 0; t < TMO; t++) begin
         @(posedge clk);
         if (s_if.awready) break;
      end
      chk("aw_accept_in_time", 64'(t < TMO), 64'd1);
      @(negedge clk);
      s_if.awvalid = 1'b0;
   endtask

   task automatic send_w(input int first, input int count, input int total, input int tag);
      int t;
      for (int b = first; b < first + count; b++) begin
         @(negedge clk);
         s_if.wvalid = 1'b1;
         s_if.wdata  = exp_data(tag, b);
         s_if.wstrb  = exp_strb(b);
         s_if.wlast  = (b == total - 1);
         for (t = 0; t < TMO; t++) begin
            @(posedge clk);
            if (s_if.wready) break;
         end
         if (t >= TMO) chk("w_beat_in_time", 64'(t), 64'(TMO - 1));
      end
      @(negedge clk);
      s_if.wvalid = 1'b0;
      s_if.wlast  = 1'b0;
   endtask

   task automatic get_b(input int hold);
      int t;
      for (t = 0; t < TMO; t++) begin
         @(negedge clk);
         if (s_if.bvalid) break;
      end
      chk("bvalid_in_time", 64'(t < TMO), 64'd1);
      repeat (hold) @(negedge clk);
      if (hold > 0) chk("bvalid_held_under_backpressure", 64'(s_if.bvalid), 64'd1);
      s_if.bready = 1'b1;
      @(negedge clk);
      s_if.bready = 1'b0;
      repeat (3) @(negedge clk);
      chk("bvalid_low_after_resp", 64'(s_if.bvalid), 64'd0);
      chk("single_upstream_b", 64'(sb_n), 64'd1);
   endtask

   task automatic check_data(input string tag, input int tagv, input int n);
      chk({tag, "_beats"}, 64'(w_n), 64'(n));
      for (int i = 0; i < n && i < 64; i++) begin
         chk({tag, "_wdata"}, 64'(w_data_log[i]), 64'(exp_data(tagv, i)));
         chk({tag, "_wstrb"}, 64'(w_strb_log[i]), 64'(exp_strb(i)));
      end
   endtask

   logic [1:0] exp_sr;

   initial begin
      rst_n = 1'b0;
      s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.bready = 1'b0; s_if.wlast = 1'b0;
      s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
      s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0; s_if.awregion = '0;
      s_if.wdata = '0; s_if.wstrb = '0;
      clear_logs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_awready", 64'(s_if.awready), 64'd0);
      chk("rst_s_wready",  64'(s_if.wready),  64'd0);
      chk("rst_s_bvalid",  64'(s_if.bvalid),  64'd0);
      chk("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
      chk("rst_m_wvalid",  64'(m_if.wvalid),  64'd0);
      chk("rst_m_bready",  64'(m_if.bready),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("awready_before_first_edge", 64'(s_if.awready), 64'd0);
      @(posedge clk);
      #1 chk("awready_after_first_edge", 64'(s_if.awready), 64'd1);

      // INCR 40 beats -> 16 + 16 + 8
      clear_logs();
      send_aw(8'h11, 32'h1000, 8'd39, 3'd2, 2'b01);
      send_w(0, 40, 40, 1);
      get_b(0);
      chk("t1_aw_count", 64'(aw_n), 64'd3);
      chk("t1_addr0", 64'(aw_addr_log[0]), 64'h1000);
      chk("t1_addr1", 64'(aw_addr_log[1]), 64'h1040);
      chk("t1_addr2", 64'(aw_addr_log[2]), 64'h1080);
      chk("t1_len0", 64'(aw_len_log[0]), 64'd15);
      chk("t1_len1", 64'(aw_len_log[1]), 64'd15);
      chk("t1_len2", 64'(aw_len_log[2]), 64'd7);
      chk("t1_wlast_count", 64'(wl_n), 64'd3);
      chk("t1_wlast0", 64'(wlast_log[0]), 64'd16);
      chk("t1_wlast1", 64'(wlast_log[1]), 64'd32);
      chk("t1_wlast2", 64'(wlast_log[2]), 64'd40);
      chk("t1_bid", 64'(sb_id), 64'h11);
      chk("t1_bresp", 64'(sb_resp), 64'd0);
      check_data("t1", 1, 40);

      // short INCR: unsplit, address unchanged
      clear_logs();
      send_aw(8'h22, 32'h2004, 8'd3, 3'd2, 2'b01);
      send_w(0, 4, 4, 2);
      get_b(0);
      chk("t2_aw_count", 64'(aw_n), 64'd1);
      chk("t2_addr", 64'(aw_addr_log[0]), 64'h2004);
      chk("t2_len", 64'(aw_len_log[0]), 64'd3);
      chk("t2_wlast", 64'(wlast_log[0]), 64'd4);
      chk("t2_bid", 64'(sb_id), 64'h22);
      check_data("t2", 2, 4);

      // WRAP 32 beats: forwarded whole
      clear_logs();
      send_aw(8'h33, 32'h3000, 8'd31, 3'd2, 2'b10);
      send_w(0, 32, 32, 3);
      get_b(0);
      chk("t3_aw_count", 64'(aw_n), 64'd1);
      chk("t3_addr", 64'(aw_addr_log[0]), 64'h3000);
      chk("t3_len", 64'(aw_len_log[0]), 64'd31);
      chk("t3_burst", 64'(aw_burst_log[0]), 64'h2);
      chk("t3_wlast_count", 64'(wl_n), 64'd1);
      chk("t3_wlast", 64'(wlast_log[0]), 64'd32);

      // B merge: OKAY then SLVERR
      clear_logs();
      plan[0] = 2'b00; plan[1] = 2'b10;
      send_aw(8'h44, 32'h6000, 8'd31, 3'd2, 2'b01);
      send_w(0, 32, 32, 4);
      get_b(0);
      chk("t4_aw_count", 64'(aw_n), 64'd2);
      chk("t4_addr1", 64'(aw_addr_log[1]), 64'h6040);
      chk("t4_bresp", 64'(sb_resp), 64'h2);

      // B merge: SLVERR then OKAY
      clear_logs();
      plan[0] = 2'b10; plan[1] = 2'b00;
      send_aw(8'h55, 32'h7000, 8'd31, 3'd2, 2'b01);
      send_w(0, 32, 32, 5);
      get_b(0);
`ifdef AXI_WR_SPLIT_WORST_RESP_EN
      exp_sr = 2'b10;
`else
      exp_sr = 2'b00;
`endif
      chk("t5_bresp", 64'(sb_resp), 64'(exp_sr));
      chk("t5_bid", 64'(sb_id), 64'h55);

      // random downstream stalls, upstream bready held off 5 cycles
      clear_logs();
      stall = 1;
      send_aw(8'h5A, 32'h4000, 8'd39, 3'd2, 2'b01);
      send_w(0, 40, 40, 6);
      get_b(5);
      stall = 0;
      chk("t6_aw_count", 64'(aw_n), 64'd3);
      chk("t6_addr2", 64'(aw_addr_log[2]), 64'h4080);
      chk("t6_wlast2", 64'(wlast_log[2]), 64'd40);
      chk("t6_bid", 64'(sb_id), 64'h5A);
      check_data("t6", 6, 40);

      // reset while beat 7 is on the W channel
      clear_logs();
      send_aw(8'h66, 32'h8000, 8'd15, 3'd2, 2'b01);
      send_w(0, 6, 16, 7);
      @(negedge clk);
      s_if.wvalid = 1'b1;
      s_if.wdata  = exp_data(7, 6);
      s_if.wstrb  = exp_strb(6);
      #1 chk("t7_wvalid_before_reset", 64'(m_if.wvalid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t7_rst_m_wvalid",  64'(m_if.wvalid),  64'd0);
      chk("t7_rst_s_wready",  64'(s_if.wready),  64'd0);
      chk("t7_rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
      chk("t7_rst_s_bvalid",  64'(s_if.bvalid),  64'd0);
      chk("t7_rst_s_awready", 64'(s_if.awready), 64'd0);
      chk("t7_rst_m_bready",  64'(m_if.bready),  64'd0);
      chk("t7_beats_before_reset", 64'(w_n), 64'd6);
      s_if.wvalid = 1'b0;
      repeat (2) @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
      send_aw(8'h77, 32'h9000, 8'd7, 3'd2, 2'b01);
      send_w(0, 8, 8, 8);
      get_b(0);
      chk("t8_aw_count", 64'(aw_n), 64'd1);
      chk("t8_addr", 64'(aw_addr_log[0]), 64'h9000);
      chk("t8_len", 64'(aw_len_log[0]), 64'd7);
      chk("t8_bid", 64'(sb_id), 64'h77);
      check_data("t8", 8, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
